// File: rtl/apb_axil_pkg.sv
// Shared types and constants for the APB slave to AXI4-Lite master bridge.
package apb_axil_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/apb_axil_bridge.sv
// APB slave to AXI4-Lite master bridge; one AXI transfer per APB transfer, same clock.
// Optional address window check enabled by defining APB_ADDR_CHECK_EN.
module apb_axil_bridge
  import apb_axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] WIN_SIZE   = 'h0001_0000
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  state_e state_q;
  logic   abort_q;
  logic   in_window;

`ifdef APB_ADDR_CHECK_EN
  // One extra bit so a window ending at the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0] WinLo = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WinHi = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};
  assign in_window = ({1'b0, PADDR} >= WinLo) && ({1'b0, PADDR} < WinHi);
`else
  assign in_window = 1'b1;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      abort_q <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      AWADDR  <= '0;
      AWVALID <= 1'b0;
      WDATA   <= '0;
      WSTRB   <= '0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARADDR  <= '0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
    end else begin
      PREADY <= 1'b0;
      // A master that drops PSEL mid-transfer gets no completion; AXI still finishes.
      if (state_q != StIdle && !PSEL) abort_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (PSEL && !PENABLE) begin
            if (!in_window) begin
              state_q <= StDone;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              if (!PWRITE) PRDATA <= '0;
            end else if (PWRITE) begin
              AWADDR  <= PADDR;
              WDATA   <= PWDATA;
              WSTRB   <= PSTRB;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state_q <= StWrReq;
            end else begin
              ARADDR  <= PADDR;
              ARVALID <= 1'b1;
              state_q <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
            BREADY  <= 1'b1;
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            if (abort_q || !PSEL) begin
              state_q <= StIdle;
            end else begin
              state_q <= StDone;
              PREADY  <= 1'b1;
              PSLVERR <= resp_is_err(BRESP);
            end
          end
        end
        StRdReq: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state_q <= StRdResp;
          end
        end
        StRdResp: begin
          if (RVALID) begin
            RREADY <= 1'b0;
            if (abort_q || !PSEL) begin
              state_q <= StIdle;
            end else begin
              state_q <= StDone;
              PREADY  <= 1'b1;
              PRDATA  <= RDATA;
              PSLVERR <= resp_is_err(RRESP);
            end
          end
        end
        StDone: begin
          PSLVERR <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_axil_bridge.sv
// Directed self-checking bench for apb_axil_bridge; honours APB_ADDR_CHECK_EN like the RTL.
module tb_apb_axil_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int total = 0;
  int bad   = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int aw0, w0;

  apb_axil_bridge dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (AWVALID && AWREADY) aw_cnt <= aw_cnt + 1;
    if (WVALID && WREADY)   w_cnt  <= w_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Drives the setup phase, advances to T1 and enters the access phase.
  task automatic apb_setup(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    tick();
    PENABLE = 1'b1;
  endtask

  task automatic apb_idle();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 2'b00;
    tick(); tick();
    check("rst_pready",  PREADY,  0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_valids",  {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    check("rst_prdata",  PRDATA,  0);
    check("rst_addrs",   {AWADDR, ARADDR}, 0);
    check("rst_wdata",   {WDATA, WSTRB}, 0);
    PRESETn = 1'b1;
    tick();

    // 1: zero-wait write
    AWREADY = 1; WREADY = 1;
    apb_setup(1, 32'h100, 32'hDEADBEEF, 4'hF);
    check("t1_aw_w_valid", {AWVALID, WVALID}, 2'b11);
    check("t1_awaddr", AWADDR, 32'h100);
    check("t1_wdata",  WDATA,  32'hDEADBEEF);
    check("t1_wstrb",  WSTRB,  4'hF);
    check("t1_pready_t1", PREADY, 0);
    tick();
    check("t1_valids_t2", {AWVALID, WVALID}, 2'b00);
    check("t1_bready_t2", BREADY, 1);
    check("t1_pready_t2", PREADY, 0);
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
    tick();
    check("t1_pready_t3", PREADY, 1);
    check("t1_pslverr",   PSLVERR, 0);
    check("t1_bready_t3", BREADY, 0);
    BVALID = 0;
    tick();
    check("t1_pready_t4", PREADY, 0);
    apb_idle();
    tick();

    // 2: read with ARREADY low for 3 cycles
    apb_setup(0, 32'h104, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check("t2_arvalid_hold", ARVALID, 1);
      check("t2_araddr", ARADDR, 32'h104);
      check("t2_pready_wait", PREADY, 0);
      if (i == 3) ARREADY = 1;
      tick();
    end
    check("t2_arvalid_drop", ARVALID, 0);
    check("t2_rready", RREADY, 1);
    ARREADY = 0; RVALID = 1; RDATA = 32'h12345678; RRESP = 2'b00;
    tick();
    check("t2_pready",  PREADY, 1);
    check("t2_prdata",  PRDATA, 32'h12345678);
    check("t2_pslverr", PSLVERR, 0);
    check("t2_rready_drop", RREADY, 0);
    RVALID = 0;
    tick();
    apb_idle();
    tick();

    // 3: W accepted at T1, AW only at T4
    aw0 = aw_cnt; w0 = w_cnt;
    WREADY = 1; AWREADY = 0;
    apb_setup(1, 32'h200, 32'h0000_00A5, 4'h1);
    check("t3_valids_t1", {AWVALID, WVALID}, 2'b11);
    tick();
    check("t3_wvalid_t2",  WVALID, 0);
    check("t3_awvalid_t2", AWVALID, 1);
    check("t3_bready_t2",  BREADY, 0);
    WREADY = 0;
    tick();
    check("t3_awvalid_t3", AWVALID, 1);
    tick();
    check("t3_awvalid_t4", AWVALID, 1);
    check("t3_bready_t4",  BREADY, 0);
    AWREADY = 1;
    tick();
    check("t3_awvalid_t5", AWVALID, 0);
    check("t3_bready_t5",  BREADY, 1);
    AWREADY = 0; BVALID = 1; BRESP = 2'b00;
    tick();
    check("t3_pready", PREADY, 1);
    check("t3_aw_hs",  aw_cnt - aw0, 1);
    check("t3_w_hs",   w_cnt - w0, 1);
    BVALID = 0;
    tick();
    apb_idle();
    tick();

    // 4: SLVERR read then DECERR write
    ARREADY = 1;
    apb_setup(0, 32'h300, 32'h0, 4'h0);
    tick();
    ARREADY = 0; RVALID = 1; RDATA = 32'hCAFE0001; RRESP = 2'b10;
    tick();
    check("t4_rd_pready",  PREADY, 1);
    check("t4_rd_pslverr", PSLVERR, 1);
    check("t4_rd_prdata",  PRDATA, 32'hCAFE0001);
    RVALID = 0;
    tick();
    apb_idle();
    tick();
    AWREADY = 1; WREADY = 1;
    apb_setup(1, 32'h304, 32'h1111_2222, 4'hC);
    tick();
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b11;
    tick();
    check("t4_wr_pready",  PREADY, 1);
    check("t4_wr_pslverr", PSLVERR, 1);
    check("t4_wr_prdata_kept", PRDATA, 32'hCAFE0001);
    BVALID = 0;
    tick();
    check("t4_pslverr_clear", PSLVERR, 0);
    apb_idle();
    tick();

    // 5: reset while waiting in WR_RESP
    AWREADY = 1; WREADY = 1;
    apb_setup(1, 32'h400, 32'h5A5A5A5A, 4'hF);
    tick();
    AWREADY = 0; WREADY = 0;
    check("t5_bready_pre", BREADY, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("t5_bready_rst", BREADY, 0);
    check("t5_pready_rst", PREADY, 0);
    check("t5_prdata_rst", PRDATA, 0);
    apb_idle();
    #2 PRESETn = 1'b1;
    tick();
    check("t5_idle_after", {AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY}, 0);
    apb_setup(0, 32'h8, 32'h0, 4'h0);
    check("t5_arvalid", ARVALID, 1);
    check("t5_araddr",  ARADDR, 32'h8);
    ARREADY = 1;
    tick();
    ARREADY = 0; RVALID = 1; RDATA = 32'h0000_0888; RRESP = 2'b01;
    tick();
    check("t5_pready",  PREADY, 1);
    check("t5_prdata",  PRDATA, 32'h0000_0888);
    check("t5_pslverr", PSLVERR, 0);
    RVALID = 0;
    tick();
    apb_idle();
    tick();

    // 6: out-of-window read
    apb_setup(0, 32'h0002_0000, 32'h0, 4'h0);
`ifdef APB_ADDR_CHECK_EN
    check("t6_no_arvalid", ARVALID, 0);
    check("t6_pready",  PREADY, 1);
    check("t6_pslverr", PSLVERR, 1);
    check("t6_prdata",  PRDATA, 0);
    tick();
    check("t6_pready_drop", PREADY, 0);
`else
    check("t6_arvalid", ARVALID, 1);
    check("t6_araddr",  ARADDR, 32'h0002_0000);
    check("t6_pready_t1", PREADY, 0);
    ARREADY = 1;
    tick();
    ARREADY = 0; RVALID = 1; RDATA = 32'h5555AAAA; RRESP = 2'b00;
    tick();
    check("t6_pready",  PREADY, 1);
    check("t6_prdata",  PRDATA, 32'h5555AAAA);
    check("t6_pslverr", PSLVERR, 0);
    RVALID = 0;
    tick();
`endif
    apb_idle();
    tick();

    // 7: PSEL dropped while waiting for R; result discarded
    ARREADY = 1;
    apb_setup(0, 32'h500, 32'h0, 4'h0);
    tick();
    ARREADY = 0;
    apb_idle();
    RVALID = 1; RDATA = 32'hBAD0_0BAD; RRESP = 2'b10;
    tick();
    check("t7_no_pready", PREADY, 0);
    check("t7_rready_drop", RREADY, 0);
    check("t7_pslverr", PSLVERR, 0);
    RVALID = 0;
    tick();
    check("t7_still_idle", {PREADY, ARVALID, AWVALID}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
